// File: rtl/srcnn_mul_arb_pkg.sv
// Shared definitions for the SRCNN multiplier-sharing arbiter.
// Holds the default operand/result widths of the generated 3x10->12
// multiplier cores and a clog2 helper used to size requester tags.
package srcnn_mul_arb_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DIN0_WIDTH = 3;
    localparam int unsigned DEF_DIN1_WIDTH = 10;
    localparam int unsigned DEF_DOUT_WIDTH = 12;
    localparam int unsigned DEF_MUL_STAGES = 1;

    // Ceiling log2, never below 1 so a tag field always exists.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned k = 1; k < 32; k++) begin
            if ((32'd1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/srcnn_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req       - request vector, one bit per requester
//   rr        - index that has highest priority this cycle
//   grant     - one-hot grant (all zero when no request)
//   grant_idx - encoded index of the granted requester (0 when none)
// The search starts at rr and wraps, so the first asserted request at or
// after rr wins.
module srcnn_rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] rr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr) + k) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = ID_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/srcnn_mul_share_arb.sv
// Shares one unsigned multiplier among NUM_REQ requesters.
// Ports:
//   ap_clk, ap_rst        - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake
//   req_din0/req_din1     - packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready   - single response handshake
//   rsp_dout/rsp_id       - low DOUT_WIDTH bits of the product and the
//                           index of the requester that issued it
//   stat_issued           - wrapping count of accepted requests
// One accept per cycle; the multiply is in stage 1 and later stages only
// carry data. The whole pipeline freezes while the output is stalled.
module srcnn_mul_share_arb
    import srcnn_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DIN0_WIDTH = DEF_DIN0_WIDTH,
    parameter int unsigned DIN1_WIDTH = DEF_DIN1_WIDTH,
    parameter int unsigned DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int unsigned MUL_STAGES = DEF_MUL_STAGES,
    parameter int unsigned ID_WIDTH   = clog2_min1(NUM_REQ)
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN0_WIDTH-1:0]  req_din0,
    input  logic [NUM_REQ*DIN1_WIDTH-1:0]  req_din1,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DOUT_WIDTH-1:0]          rsp_dout,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [15:0]                    stat_issued
);

    typedef struct packed {
        logic                  valid;
        logic [ID_WIDTH-1:0]   id;
        logic [DOUT_WIDTH-1:0] dout;
    } stage_t;

    stage_t                stage_q [MUL_STAGES];
    stage_t                stage_d [MUL_STAGES];
    logic [ID_WIDTH-1:0]   rr_q, rr_d;
    logic [15:0]           stat_q, stat_d;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic                  stall;
    logic                  accept;
    logic [DIN0_WIDTH-1:0] a_sel;
    logic [DIN1_WIDTH-1:0] b_sel;

    srcnn_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req       (req_valid),
        .rr        (rr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign stall     = stage_q[MUL_STAGES-1].valid & ~rsp_ready;
    assign req_ready = (ap_rst || stall) ? '0 : grant;
    assign accept    = |(req_valid & req_ready);

    assign a_sel = req_din0[grant_idx*DIN0_WIDTH +: DIN0_WIDTH];
    assign b_sel = req_din1[grant_idx*DIN1_WIDTH +: DIN1_WIDTH];

    always_comb begin
        rr_d   = rr_q;
        stat_d = stat_q;
        for (int unsigned s = 0; s < MUL_STAGES; s++) begin
            stage_d[s] = stage_q[s];
        end

        if (accept) begin
            rr_d   = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            stat_d = stat_q + 16'd1;
        end

        if (!stall) begin
            // Idle cycles load an all-zero bubble.
            stage_d[0] = '0;
            if (accept) begin
                stage_d[0].valid = 1'b1;
                stage_d[0].id    = grant_idx;
                // Multiplying at result width gives the same low bits as
                // the full-width product.
                stage_d[0].dout  = DOUT_WIDTH'(a_sel) * DOUT_WIDTH'(b_sel);
            end
            for (int unsigned s = 1; s < MUL_STAGES; s++) begin
                stage_d[s] = stage_q[s-1];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_q   <= '0;
            stat_q <= '0;
            for (int unsigned s = 0; s < MUL_STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            rr_q   <= rr_d;
            stat_q <= stat_d;
            for (int unsigned s = 0; s < MUL_STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign rsp_valid   = stage_q[MUL_STAGES-1].valid;
    assign rsp_dout    = stage_q[MUL_STAGES-1].dout;
    assign rsp_id      = stage_q[MUL_STAGES-1].id;
    assign stat_issued = stat_q;

endmodule

// File: tb/tb_srcnn_mul_share_arb.sv
// Bench for srcnn_mul_share_arb: directed scenarios followed by random
// traffic, compared each cycle against a queue-based reference model.
module tb_srcnn_mul_share_arb;

    localparam int unsigned N   = 4;
    localparam int unsigned W0  = 3;
    localparam int unsigned W1  = 10;
    localparam int unsigned WO  = 12;
    localparam int unsigned MS  = 2;
    localparam int unsigned IDW = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W0-1:0]   req_din0;
    logic [N*W1-1:0]   req_din1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WO-1:0]     rsp_dout;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       stat_issued;

    always #5 ap_clk = ~ap_clk;

    srcnn_mul_share_arb #(
        .NUM_REQ    (N),
        .DIN0_WIDTH (W0),
        .DIN1_WIDTH (W1),
        .DOUT_WIDTH (WO),
        .MUL_STAGES (MS),
        .ID_WIDTH   (IDW)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_din0    (req_din0),
        .req_din1    (req_din1),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dout    (rsp_dout),
        .rsp_id      (rsp_id),
        .stat_issued (stat_issued)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    // Reference model: in-flight items in accept order, each with the
    // number of pipeline advances it has seen since being accepted.
    typedef struct {
        int unsigned id;
        int unsigned dout;
        int unsigned pos;
    } item_t;

    item_t       inflight[$];
    int unsigned m_rr      = 0;
    int unsigned m_stat    = 0;
    bit          after_rst = 1'b0;

    function automatic int first_from(input logic [N-1:0] v, input int unsigned start);
        for (int unsigned k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return int'((start + k) % N);
        end
        return -1;
    endfunction

    task automatic cycle(input logic rst, input logic [N-1:0] v,
                         input logic [N*W0-1:0] a, input logic [N*W1-1:0] b,
                         input logic rdy);
        int          g;
        bit          head_vis;
        bit          stall_m;
        logic [N-1:0] exp_ready;
        item_t       it;
        int unsigned av, bv;

        @(negedge ap_clk);
        ap_rst    = rst;
        req_valid = v;
        req_din0  = a;
        req_din1  = b;
        rsp_ready = rdy;
        #1;
        head_vis  = (inflight.size() > 0) && (inflight[0].pos == MS);
        stall_m   = head_vis && !rdy;
        g         = first_from(v, m_rr);
        exp_ready = '0;
        if (!rst && !stall_m && g >= 0) exp_ready[g] = 1'b1;

        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(head_vis));
        if (head_vis) begin
            check_eq("rsp_dout", 32'(rsp_dout), inflight[0].dout);
            check_eq("rsp_id",   32'(rsp_id),   inflight[0].id);
        end else if (after_rst) begin
            check_eq("rsp_dout_rst", 32'(rsp_dout), 32'd0);
            check_eq("rsp_id_rst",   32'(rsp_id),   32'd0);
        end
        check_eq("stat_issued", 32'(stat_issued), m_stat);

        @(posedge ap_clk);
        after_rst = 1'b0;
        if (rst) begin
            inflight.delete();
            m_rr      = 0;
            m_stat    = 0;
            after_rst = 1'b1;
        end else if (!stall_m) begin
            if (head_vis) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].pos = inflight[i].pos + 1;
            if (g >= 0) begin
                av      = 32'(a[g*W0 +: W0]);
                bv      = 32'(b[g*W1 +: W1]);
                it.id   = int'(g);
                it.dout = (av * bv) % (1 << WO);
                it.pos  = 1;
                inflight.push_back(it);
                m_rr   = (int'(g) + 1) % N;
                m_stat = (m_stat + 1) % 65536;
            end
        end
    endtask

    logic [N*W0-1:0] a;
    logic [N*W1-1:0] b;

    initial begin
        ap_rst    = 1'b1;
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        rsp_ready = 1'b1;

        repeat (2) cycle(1'b1, '0, '0, '0, 1'b1);

        // Single request from requester 0: 5 * 100.
        a = '0; b = '0;
        a[0 +: W0] = 3'd5;
        b[0 +: W1] = 10'd100;
        cycle(1'b0, 4'b0001, a, b, 1'b1);
        repeat (3) cycle(1'b0, '0, a, b, 1'b1);

        // Truncation on requester 1: 7 * 1023 = 7161 -> 3065.
        a = '0; b = '0;
        a[1*W0 +: W0] = 3'd7;
        b[1*W1 +: W1] = 10'd1023;
        cycle(1'b0, 4'b0010, a, b, 1'b1);
        repeat (3) cycle(1'b0, '0, a, b, 1'b1);

        // All requesters valid, back-to-back grants.
        for (int i = 0; i < 8; i++) begin
            a = 12'($urandom);
            b = 40'({$urandom, $urandom});
            cycle(1'b0, 4'b1111, a, b, 1'b1);
        end

        // Backpressure with the pipeline full.
        for (int i = 0; i < 10; i++) begin
            a = 12'($urandom);
            b = 40'({$urandom, $urandom});
            cycle(1'b0, 4'b1111, a, b, (i >= 2 && i < 5) ? 1'b0 : 1'b1);
        end
        repeat (4) cycle(1'b0, '0, a, b, 1'b1);

        // Fairness: requester 2 always, requester 0 joins at cycle 5.
        for (int i = 0; i < 12; i++) begin
            a = 12'($urandom);
            b = 40'({$urandom, $urandom});
            cycle(1'b0, (i >= 5) ? 4'b0101 : 4'b0100, a, b, 1'b1);
        end
        repeat (4) cycle(1'b0, '0, a, b, 1'b1);

        // Reset with two requests in flight, then lowest valid index wins.
        a = 12'($urandom);
        b = 40'({$urandom, $urandom});
        cycle(1'b0, 4'b1100, a, b, 1'b0);
        cycle(1'b0, 4'b1100, a, b, 1'b0);
        cycle(1'b1, 4'b1100, a, b, 1'b0);
        cycle(1'b0, 4'b1010, a, b, 1'b1);
        repeat (4) cycle(1'b0, '0, a, b, 1'b1);

        // Random traffic with random backpressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            a = 12'($urandom);
            b = 40'({$urandom, $urandom});
            cycle(($urandom_range(0, 255) == 0) ? 1'b1 : 1'b0,
                  N'($urandom),
                  a, b,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        repeat (6) cycle(1'b0, '0, a, b, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
